micro_hash_core: RTL
====================

# micro_hash_core

Sequential hashing engine directly downstream of the block concatenator. It accepts the 16-byte block (12 data bytes followed by 4 nonce bytes), expands it to a 32-byte schedule, and runs 32 compression rounds to produce a 24-bit hash. It also flags whether that hash meets the difficulty target; the nonce-search control logic consumes this flag.

## Interface
- `ROUNDS`, 32: compression rounds. The schedule depth equals `ROUNDS`; only 32 is supported.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `start`  in  1  request; sampled only in IDLE.
- `block_in`  in  128  concatenator output. Byte i is `block_in[127-8i -: 8]`, so W[0] is the MSB byte and W[12..15] are the nonce bytes.
- `target`  in  8  difficulty threshold; sampled on the same edge as `start`.
- `busy`  out  1  high in EXPAND and ROUND.
- `done`  out  1  one-cycle pulse; high only in DONE.
- `hash_out`  out  24  {H0,H1,H2} from the last completed hash.
- `hash_valid`  out  1  (H0 < target) && (H1 < target), unsigned strict compare, registered with `hash_out`.

## Operation
- **States:** IDLE, EXPAND, ROUND, DONE. A 5-bit index counter tracks progress.
- **IDLE:**
  - On `start`=1: capture `block_in` into W[0..15] and `target` into a register.
  - Set H0=0x01, H1=0x89, H2=0xFE, then go to EXPAND with idx=16.
  - On `start`=0: stay in IDLE.
- **EXPAND:**
  - Each cycle: W[idx] = (W[idx-3] | W[idx-9]) ^ W[idx-14] (all 8-bit), then idx++.
  - After W[31] is written, go to ROUND with idx=0.
- **ROUND** (round i = idx):
  - For i ≤ 16: k=0x99, x=H1^H2. For i ≥ 17: k=0xA1, x=H1|H2.
  - t = (H0 + x + k + W[i]) mod 256. The sum is truncated to 8 bits and the carry is discarded.
  - Update all three simultaneously: H0' = H1^H2, H1' = rotl2(t) = {t[5:0],t[7:6]}, H2' = H0^t.
  - After round 31, load `hash_out`={H0',H1',H2'} and `hash_valid` from the latched target, then go to DONE.
- **DONE:** `done`=1 for one cycle, then return to IDLE unconditionally.
- **Other `start` rules:**
  - `start` in EXPAND, ROUND or DONE is ignored and not queued.
  - `block_in` and `target` may change freely after the accepting edge.
- **Output holding:** `hash_out` and `hash_valid` hold their values until the next completion. Only reset clears them.

## Timing
- **Reset (async assert):**
  - State goes to IDLE immediately, idx=0.
  - `busy`=0, `done`=0, `hash_out`=0, `hash_valid`=0.
  - W, H and the latched target are cleared to 0.
- **Reset release:** the first active edge after `reset` rises may accept `start`.
- **Reset mid-operation:** the run is aborted, no `done` is produced, and the previous `hash_out` is lost (reads 0).
- **Latency:**
  - Edge E0 accepts `start`.
  - Edges E1–E16 run EXPAND.
  - Edges E17–E48 run rounds 0–31.
  - E48 loads `hash_out`, `hash_valid` and enters DONE.
  - `done` is high between E48 and E49. `busy` is high between E0 and E48.
- **Throughput:** the earliest next accept is E50, a 50-cycle period. `start` held high continuously restarts at E50 with a freshly sampled `block_in`.
- **Stale outputs:** `hash_out` is updated only at the completion edge; the old value stays visible throughout busy.

## Test plan
- **Reset values:** assert `reset`=0 mid-cycle → all outputs 0 asynchronously, before the next edge; hold 3 cycles; release → IDLE, `busy`=0.
- **Latency:** `block_in`=128'h0, `target`=8'hFF, `start` pulse at E0 →
  - `busy` high for exactly 48 cycles;
  - `done` high exactly 1 cycle, after E48;
  - `hash_out` equals the golden model, and `hash_valid` matches (H0<0xFF && H1<0xFF).
- **Target boundary:**
  - Same block with `target`=8'h00 → `hash_valid`=0, since the compare is strict.
  - Rerun with `target` = max(H0,H1)+1 from the golden model → `hash_valid`=1.
- **Ignored start:**
  - Pulse `start` with a different block at E10 (EXPAND) and at E30 (ROUND) → result identical to the single-start run; still one `done`.
  - `start` held high → second accept at E50, and its `done` follows after E98.
- **Reset mid-run:** drop `reset` at E25 → `busy`/`done`/`hash_out` = 0 immediately; after release, a new start with block 128'h0102…10 completes normally in 48 cycles with the golden hash.
- **Sweep:** 200 random blocks/targets back-to-back → every `hash_out`/`hash_valid` matches the golden model (including schedule precedence and 8-bit wrap of t); `hash_out` is unchanged while busy.

Source files
------------

// File: rtl/micro_hash_core.sv
// micro_hash_core: sequential 24-bit hash over a 16-byte block.
// The 16 input bytes are expanded to a 32-byte schedule, then 32 compression
// rounds run over H0/H1/H2. The result and its difficulty flag are held until
// the next completion.
module micro_hash_core #(
    parameter int unsigned ROUNDS = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] block_in,
    input  logic [7:0]   target,
    output logic         busy,
    output logic         done,
    output logic [23:0]  hash_out,
    output logic         hash_valid
);

    localparam logic [4:0] LAST_IDX = 5'(ROUNDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        ROUND,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [7:0]  w_q [ROUNDS];
    logic [7:0]  w_d [ROUNDS];
    logic [7:0]  h0_q, h0_d;
    logic [7:0]  h1_q, h1_d;
    logic [7:0]  h2_q, h2_d;
    logic [7:0]  target_q, target_d;
    logic [23:0] hash_q, hash_d;
    logic        valid_q, valid_d;

    logic [7:0]  rk, rx, rt, rt_rot, h0_next, h2_next;

    // Round function for the current index; only consumed in ROUND.
    always_comb begin
        rk      = (idx_q <= 5'd16) ? 8'h99 : 8'hA1;
        rx      = (idx_q <= 5'd16) ? (h1_q ^ h2_q) : (h1_q | h2_q);
        rt      = h0_q + rx + rk + w_q[idx_q];
        rt_rot  = {rt[5:0], rt[7:6]};
        h0_next = h1_q ^ h2_q;
        h2_next = h0_q ^ rt;
    end

    // Next-state, schedule expansion and compression update.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        w_d      = w_q;
        h0_d     = h0_q;
        h1_d     = h1_q;
        h2_d     = h2_q;
        target_d = target_q;
        hash_d   = hash_q;
        valid_d  = valid_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    for (int unsigned i = 0; i < 16; i++) begin
                        w_d[i] = block_in[127 - 8*i -: 8];
                    end
                    target_d = target;
                    h0_d     = 8'h01;
                    h1_d     = 8'h89;
                    h2_d     = 8'hFE;
                    idx_d    = 5'd16;
                    state_d  = EXPAND;
                end
            end
            EXPAND: begin
                w_d[idx_q] = (w_q[idx_q - 5'd3] | w_q[idx_q - 5'd9]) ^ w_q[idx_q - 5'd14];
                idx_d      = idx_q + 5'd1;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                h0_d  = h0_next;
                h1_d  = rt_rot;
                h2_d  = h2_next;
                idx_d = idx_q + 5'd1;
                if (idx_q == LAST_IDX) begin
                    hash_d  = {h0_next, rt_rot, h2_next};
                    valid_d = (h0_next < target_q) && (rt_rot < target_q);
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything including the result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            for (int unsigned i = 0; i < ROUNDS; i++) begin
                w_q[i] <= '0;
            end
            h0_q     <= '0;
            h1_q     <= '0;
            h2_q     <= '0;
            target_q <= '0;
            hash_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            w_q      <= w_d;
            h0_q     <= h0_d;
            h1_q     <= h1_d;
            h2_q     <= h2_d;
            target_q <= target_d;
            hash_q   <= hash_d;
            valid_q  <= valid_d;
        end
    end

    assign busy       = (state_q == EXPAND) || (state_q == ROUND);
    assign done       = (state_q == DONE);
    assign hash_out   = hash_q;
    assign hash_valid = valid_q;

endmodule
